// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI burst memory: FSM states, R/W bit
// encoding and the minimum sclk phase length the input conditioner needs.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RW,
    ST_WRITE,
    ST_COMMIT,
    ST_READ,
    ST_HOLD
  } spi_state_e;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

  localparam int SPI_MIN_SYNC     = 2;
  localparam int SPI_PHASE_MARGIN = 3;

  // Shortest sclk high/low phase, in clk cycles, that edge detection can resolve.
  function automatic int spi_min_phase(input int sync_stages);
    return sync_stages + SPI_PHASE_MARGIN;
  endfunction

endpackage

// File: rtl/input_conditioner.sv
// Multi-flop synchroniser for one asynchronous pin, with one-clk-wide
// rise/fall pulses taken from the last two synchronised samples.
module input_conditioner #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_out   = sync_q[STAGES-1];
  assign rise_pulse =  sync_q[STAGES-1] & ~prev_q;
  assign fall_pulse = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave in front of a 2**ADDR_W x DATA_W register file.
// Define SPI_BURST_EN for auto-incrementing multi-word frames; otherwise one word per frame.
module spi_burst_memory
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic [3:0] leds
);

  localparam int SS    = (SYNC_STAGES < SPI_MIN_SYNC) ? SPI_MIN_SYNC : SYNC_STAGES;
  localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
  localparam int DEPTH = 2**ADDR_W;
`ifdef SPI_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  logic sclk_rise, sclk_fall, cs_s, mosi_s;
  logic sclk_sync_unused, cs_rise_unused, cs_fall_unused, mosi_rise_unused, mosi_fall_unused;

  input_conditioner #(.STAGES(SS), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .pin(sclk_pin),
    .sync_out(sclk_sync_unused), .rise_pulse(sclk_rise), .fall_pulse(sclk_fall));
  input_conditioner #(.STAGES(SS), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .pin(cs_pin),
    .sync_out(cs_s), .rise_pulse(cs_rise_unused), .fall_pulse(cs_fall_unused));
  input_conditioner #(.STAGES(SS), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .pin(mosi_pin),
    .sync_out(mosi_s), .rise_pulse(mosi_rise_unused), .fall_pulse(mosi_fall_unused));

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   shift_q;
  logic                load_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic last_addr, last_data;
  logic addr_shift, data_shift, commit, miso_shift, rd_enter, rd_word_done;
  logic cnt_clr, cnt_inc, addr_inc;

  assign last_addr = (bit_cnt == CNT_W'(ADDR_W-1));
  assign last_data = (bit_cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!cs_s) state_d = ST_ADDR;
      ST_ADDR:   if (sclk_rise && last_addr) state_d = ST_RW;
      ST_RW: begin
        if (sclk_rise && mosi_s == SPI_RW_READ)  state_d = ST_READ;
        if (sclk_rise && mosi_s == SPI_RW_WRITE) state_d = ST_WRITE;
      end
      ST_WRITE:  if (sclk_rise && last_data) state_d = ST_COMMIT;
      ST_COMMIT: state_d = BURST ? ST_WRITE : ST_HOLD;
      ST_READ:   if (sclk_rise && last_data && !BURST) state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_HOLD;
      default:   state_d = ST_IDLE;
    endcase
    // Deselect wins everywhere; COMMIT still writes because the write keys off state_q.
    if (cs_s && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_comb begin
    addr_shift   = (state_q == ST_ADDR)  && sclk_rise;
    data_shift   = (state_q == ST_WRITE) && sclk_rise;
    commit       = (state_q == ST_COMMIT);
    miso_shift   = (state_q == ST_READ)  && sclk_fall;
    rd_enter     = (state_q == ST_RW)    && sclk_rise && (mosi_s == SPI_RW_READ);
    rd_word_done = (state_q == ST_READ)  && sclk_rise && last_data;
    cnt_clr      = (state_q == ST_IDLE) || (state_q == ST_RW) || commit || rd_word_done;
    cnt_inc      = sclk_rise && (state_q == ST_ADDR || state_q == ST_WRITE || state_q == ST_READ);
    addr_inc     = BURST && (commit || rd_word_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      load_q   <= 1'b0;
      miso_pin <= 1'b0;
      miso_oe  <= 1'b0;
      leds     <= 4'h0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
      load_q <= rd_enter || (BURST && rd_word_done);
      if (state_d != ST_READ) begin
        miso_pin <= 1'b0;
        miso_oe  <= 1'b0;
      end else if (miso_shift) begin
        miso_pin <= shift_q[DATA_W-1];
        miso_oe  <= 1'b1;
      end
      if (commit) leds <= 4'(shift_q);
    end
  end

  // Address and shift registers survive deselect; only the next frame overwrites them.
  always_ff @(posedge clk) begin
    if (addr_shift)    addr_q <= ADDR_W'({addr_q, mosi_s});
    else if (addr_inc) addr_q <= addr_q + 1'b1;
    if (data_shift)      shift_q <= DATA_W'({shift_q, mosi_s});
    else if (load_q)     shift_q <= mem[addr_q];
    else if (miso_shift) shift_q <= shift_q << 1;
  end

  always_ff @(posedge clk) begin
    if (commit && !reset) mem[addr_q] <= shift_q;
  end

endmodule

// File: tb/tb_spi_burst_memory.sv
// Scoreboard bench for spi_burst_memory: read words are queued at stimulus
// time and compared by a MISO monitor; leds/idle-MISO are checked inline.
module tb_spi_burst_memory;

  localparam int HALF = 10;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk_pin = 1'b0;
  logic       cs_pin = 1'b1;
  logic       mosi_pin = 1'b0;
  logic       miso_pin, miso_oe;
  logic [3:0] leds;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_burst_memory #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .miso_pin(miso_pin), .miso_oe(miso_oe), .leds(leds));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SPI bit: set MOSI while sclk low, then a full high phase.
  task automatic spi_bit(input logic b, input logic chk_idle);
    mosi_pin = b;
    tick(HALF);
    if (chk_idle) check("miso_idle", {6'd0, miso_oe, miso_pin}, 8'h00);
    sclk_pin = 1'b1;
    tick(HALF);
    sclk_pin = 1'b0;
  endtask

  task automatic frame_begin();
    cs_pin = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end();
    tick(HALF);
    cs_pin = 1'b1;
    tick(2*HALF);
  endtask

  task automatic send_hdr(input logic [6:0] a, input logic rw);
    for (int i = 6; i >= 0; i--) spi_bit(a[i], 1'b1);
    spi_bit(rw, 1'b1);
  endtask

  // d holds up to three words, first word in the top byte.
  task automatic spi_write(input logic [6:0] a, input logic [23:0] d, input int n);
    frame_begin();
    send_hdr(a, 1'b0);
    for (int w = 0; w < n; w++)
      for (int i = 7; i >= 0; i--) spi_bit(d[16-8*w+i], 1'b1);
    frame_end();
  endtask

  task automatic spi_read(input logic [6:0] a, input int n);
    frame_begin();
    send_hdr(a, 1'b1);
    for (int w = 0; w < n; w++)
      for (int i = 7; i >= 0; i--) spi_bit(1'b0, (w > 0) && !BURST);
    frame_end();
  endtask

  initial begin
    fork
      begin : monitor
        logic [7:0] sh;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
          @(posedge sclk_pin or posedge cs_pin);
          if (cs_pin) nb = 0;
          else if (miso_oe) begin
            sh = {sh[6:0], miso_pin};
            nb++;
            if (nb == 8) begin
              nb = 0;
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h expected no word", sh);
              end else check("rd_word", sh, exp_q.pop_front());
            end
          end
        end
      end
    join_none

    reset = 1'b1;
    tick(5);
    check("rst_miso", {7'd0, miso_pin}, 8'h00);
    check("rst_oe",   {7'd0, miso_oe},  8'h00);
    check("rst_leds", {4'd0, leds},     8'h00);
    reset = 1'b0;
    tick(5);

    // Known contents at the wrap targets of the burst test.
    spi_write(7'h00, 24'h5C0000, 1);
    spi_write(7'h01, 24'h6D0000, 1);
    check("leds_6d", {4'd0, leds}, 8'h0D);

    spi_write(7'h44, 24'hBB0000, 1);
    check("leds_bb", {4'd0, leds}, 8'h0B);
    exp_q.push_back(8'hBB);
    spi_read(7'h44, 1);

    spi_write(7'h45, 24'hAA0000, 1);
    check("leds_aa", {4'd0, leds}, 8'h0A);
    exp_q.push_back(8'hBB);
    spi_read(7'h44, 1);
    exp_q.push_back(8'hAA);
    spi_read(7'h45, 1);

    // Three-word write starting at the top address.
    spi_write(7'h7F, 24'h112233, 3);
    check("leds_burst", {4'd0, leds}, BURST ? 8'h03 : 8'h01);
    exp_q.push_back(8'h11);
    if (BURST) begin
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
    end
    spi_read(7'h7F, 3);
    exp_q.push_back(BURST ? 8'h22 : 8'h5C);
    spi_read(7'h00, 1);
    exp_q.push_back(BURST ? 8'h33 : 8'h6D);
    spi_read(7'h01, 1);

    // Aborted write after 5 of 8 data bits.
    spi_write(7'h10, 24'h5A0000, 1);
    check("leds_5a", {4'd0, leds}, 8'h0A);
    frame_begin();
    send_hdr(7'h10, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
    frame_end();
    check("leds_abort", {4'd0, leds}, 8'h0A);
    exp_q.push_back(8'h5A);
    spi_read(7'h10, 1);

    // Reset in the middle of the address phase.
    frame_begin();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b1);
    reset = 1'b1;
    tick(3);
    check("midrst_oe",   {7'd0, miso_oe},  8'h00);
    check("midrst_miso", {7'd0, miso_pin}, 8'h00);
    check("midrst_leds", {4'd0, leds},     8'h00);
    reset = 1'b0;
    tick(2);
    cs_pin = 1'b1;
    tick(2*HALF);
    spi_write(7'h02, 24'hC30000, 1);
    check("leds_c3", {4'd0, leds}, 8'h03);
    exp_q.push_back(8'hC3);
    spi_read(7'h02, 1);

    tick(2*HALF);
    check("rd_pending", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
